sdram_port_arb: RTL and testbench

- Shares one bank port of the 64-bit SDRAM controller (rden/wren/addr/valid/fetch/wr_bena/wr_data) between NUM_REQ requesters, for example the CPU, DMA and the video ROM loader.
- Arbitrates round-robin or fixed-priority and sequences each read or write to the controller's slot handshake.
- Holds write data through the fetch-to-p2 window and returns registered read data with a one-cycle ack.
- Sits between client logic and one rden_bN/wren_bN port group of the controller.

---
 rtl/sdram_port_arb_pkg.sv | 16 +
 rtl/sdram_port_arb_if.sv | 26 ++
 rtl/sdram_port_arb_rr_picker.sv | 45 ++++
 rtl/sdram_port_arb.sv | 123 ++++++++++++
 tb/tb_sdram_port_arb.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_port_arb_pkg.sv
// Shared types and widths for the SDRAM bank-port arbiter.
package sdram_arb_pkg;

  localparam int DQ_W = 64;
  localparam int BE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_WR_P1,
    ST_WR_P2,
    ST_DONE
  } arb_state_t;

endpackage

// File: rtl/sdram_port_arb_if.sv
// One rden_bN/wren_bN port group of the 64-bit SDRAM controller.
interface sdram_port_arb_if #(
  parameter int ADDR_W = 32
);

  logic                             ram_rdy_n;
  logic [sdram_arb_pkg::DQ_W-1:0]   rd_data;
  logic                             valid_b;
  logic                             fetch_b;
  logic                             rden_b;
  logic                             wren_b;
  logic [ADDR_W-1:0]                addr_b;
  logic [sdram_arb_pkg::BE_W-1:0]   wr_bena_b;
  logic [sdram_arb_pkg::DQ_W-1:0]   wr_data_b;

  modport master (
    input  ram_rdy_n, rd_data, valid_b, fetch_b,
    output rden_b, wren_b, addr_b, wr_bena_b, wr_data_b
  );

  modport slave (
    output ram_rdy_n, rd_data, valid_b, fetch_b,
    input  rden_b, wren_b, addr_b, wr_bena_b, wr_data_b
  );

endinterface

// File: rtl/sdram_port_arb_rr_picker.sv
// Combinational one-hot request picker; owns the round-robin pointer.
module rr_picker #(
  parameter int NUM_REQ   = 3,
  parameter int PRIO_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       grant_en,
  output logic [NUM_REQ-1:0]         gnt_oh,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;

  // Scan from the pointer (round-robin) or from index 0 (fixed priority).
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    found   = 1'b0;
    idx     = '0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PRIO_MODE != 0) idx = IDX_W'(i);
      else                idx = IDX_W'((i + 32'(ptr)) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Shares one SDRAM controller bank port between NUM_REQ requesters and
// sequences each access through the controller's valid/fetch handshake.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DQ_W-1:0]   wdata_i,
  input  logic [NUM_REQ*BE_W-1:0]   bena_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DQ_W-1:0]           rdata_o,
  sdram_port_arb_if.master          ram
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t       state;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] g_q;
  logic [CNT_W-1:0] wd_cnt;
  logic             grant_en;
  logic             wd_fire;

  assign grant_en = (state == ST_IDLE) && !ram.ram_rdy_n && (|gnt_oh);
  assign wd_fire  = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .PRIO_MODE (PRIO_MODE)
  ) u_picker (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .grant_en (grant_en),
    .gnt_oh   (gnt_oh),
    .gnt_idx  (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      g_q           <= '0;
      wd_cnt        <= '0;
      ack_o         <= '0;
      err_o         <= '0;
      rdata_o       <= '0;
      ram.rden_b    <= 1'b0;
      ram.wren_b    <= 1'b0;
      ram.addr_b    <= '0;
      ram.wr_bena_b <= '0;
      ram.wr_data_b <= '0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            g_q        <= gnt_idx;
            wd_cnt     <= '0;
            ram.addr_b <= addr_i[gnt_idx*ADDR_W +: ADDR_W];
            if (we_i[gnt_idx]) begin
              ram.wren_b    <= 1'b1;
              ram.wr_data_b <= wdata_i[gnt_idx*DQ_W +: DQ_W];
              ram.wr_bena_b <= bena_i[gnt_idx*BE_W +: BE_W];
              state         <= ST_WR_WAIT;
            end else begin
              ram.rden_b <= 1'b1;
              state      <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (ram.valid_b) begin
            rdata_o    <= ram.rd_data;
            ram.rden_b <= 1'b0;
            ack_o[g_q] <= 1'b1;
            state      <= ST_DONE;
          end else if (wd_fire) begin
            ram.rden_b <= 1'b0;
            err_o[g_q] <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (ram.fetch_b) begin
            ram.wren_b <= 1'b0;
            state      <= ST_WR_P1;
          end else if (wd_fire) begin
            ram.wren_b    <= 1'b0;
            ram.wr_bena_b <= '0;
            err_o[g_q]    <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_WR_P1: state <= ST_WR_P2;
        // Data/bena stay valid through p2; byte enables close as we leave it.
        ST_WR_P2: begin
          ram.wr_bena_b <= '0;
          ack_o[g_q]    <= 1'b1;
          state         <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Self-checking bench for sdram_port_arb with a controller-side stub and
// a queue-free round-robin reference model.
module tb_sdram_port_arb;
  import sdram_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req, req_fx, we;
  logic [N*AW-1:0] addr;
  logic [N*64-1:0] wdata;
  logic [N*8-1:0]  bena;
  logic [N-1:0]    ack, err, ack_fx, err_fx;
  logic [63:0]     rdata, rdata_fx;

  sdram_port_arb_if #(.ADDR_W(AW)) bus_rr ();
  sdram_port_arb_if #(.ADDR_W(AW)) bus_fx ();

  sdram_port_arb #(.NUM_REQ(N), .ADDR_W(AW), .PRIO_MODE(0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .bena_i(bena), .ack_o(ack), .err_o(err), .rdata_o(rdata),
    .ram(bus_rr.master)
  );

  sdram_port_arb #(.NUM_REQ(N), .ADDR_W(AW), .PRIO_MODE(1), .TIMEOUT(1024)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_i(req_fx), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .bena_i(bena), .ack_o(ack_fx), .err_o(err_fx), .rdata_o(rdata_fx),
    .ram(bus_fx.master)
  );

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;  // model: requester with top priority for the next grant

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return 0;
  endfunction

  task automatic wait_en(output int cyc);
    cyc = 0;
    while (!(bus_rr.rden_b || bus_rr.wren_b) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_fx = '0;
    bus_rr.valid_b = 1'b0;
    bus_rr.fetch_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '1;
    we = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_rr.rden_b, bus_rr.wren_b, bus_rr.wr_bena_b, ack, err, rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs rden=%b wren=%b bena=%h ack=%b err=%b rdata=%h exp all 0",
               bus_rr.rden_b, bus_rr.wren_b, bus_rr.wr_bena_b, ack, err, rdata);
    end
    total++;
    if ({bus_fx.rden_b, bus_fx.wren_b, ack_fx, err_fx} !== '0) begin
      bad++;
      $display("FAIL reset_outputs_fx rden=%b wren=%b ack=%b err=%b exp 0",
               bus_fx.rden_b, bus_fx.wren_b, ack_fx, err_fx);
    end
    req = '0;
    rst_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int c;
    addr[0 +: AW] = 32'h0000_1000;
    we = '0;
    req = 3'b001;
    wait_en(c);
    total++;
    if ({bus_rr.rden_b, bus_rr.wren_b} !== 2'b10 || c != 1) begin
      bad++;
      $display("FAIL rd_start rden/wren=%b%b cycles=%0d exp 10 after 1", bus_rr.rden_b, bus_rr.wren_b, c);
    end
    total++;
    if (bus_rr.addr_b !== 32'h0000_1000) begin
      bad++;
      $display("FAIL rd_addr got=%h exp=00001000", bus_rr.addr_b);
    end
    repeat (5) @(negedge clk);
    total++;
    if (bus_rr.rden_b !== 1'b1 || ack !== 3'b000) begin
      bad++;
      $display("FAIL rd_hold rden=%b ack=%b exp 1/000", bus_rr.rden_b, ack);
    end
    bus_rr.valid_b = 1'b1;
    bus_rr.rd_data = 64'h0123456789ABCDEF;
    @(negedge clk);
    bus_rr.valid_b = 1'b0;
    req = '0;
    total++;
    if (bus_rr.rden_b !== 1'b0 || ack !== 3'b001 || rdata !== 64'h0123456789ABCDEF) begin
      bad++;
      $display("FAIL rd_ack rden=%b ack=%b rdata=%h exp 0/001/0123456789abcdef", bus_rr.rden_b, ack, rdata);
    end
    @(negedge clk);
    total++;
    if (ack !== 3'b000) begin
      bad++;
      $display("FAIL rd_ack_pulse ack=%b exp 000", ack);
    end
    ptr_m = 1;
  endtask

  task automatic test_single_write();
    int c;
    addr[AW +: AW] = 32'h0000_2000;
    wdata[64 +: 64] = 64'hDEADBEEF_CAFEF00D;
    bena[8 +: 8] = 8'h0F;
    we = 3'b010;
    req = 3'b010;
    wait_en(c);
    total++;
    if ({bus_rr.rden_b, bus_rr.wren_b} !== 2'b01 || bus_rr.addr_b !== 32'h0000_2000) begin
      bad++;
      $display("FAIL wr_start rden/wren=%b%b addr=%h exp 01/00002000", bus_rr.rden_b, bus_rr.wren_b, bus_rr.addr_b);
    end
    repeat (2) @(negedge clk);
    bus_rr.fetch_b = 1'b1;
    @(negedge clk);
    bus_rr.fetch_b = 1'b0;
    total++;
    if (bus_rr.wren_b !== 1'b0) begin
      bad++;
      $display("FAIL wr_drop wren=%b exp 0", bus_rr.wren_b);
    end
    @(negedge clk);
    total++;
    if (bus_rr.wr_data_b !== 64'hDEADBEEF_CAFEF00D || bus_rr.wr_bena_b !== 8'h0F || ack !== 3'b000) begin
      bad++;
      $display("FAIL wr_p2 data=%h bena=%h ack=%b exp deadbeefcafef00d/0f/000",
               bus_rr.wr_data_b, bus_rr.wr_bena_b, ack);
    end
    @(negedge clk);
    req = '0;
    total++;
    if (ack !== 3'b010 || bus_rr.wr_bena_b !== 8'h00) begin
      bad++;
      $display("FAIL wr_ack ack=%b bena=%h exp 010/00", ack, bus_rr.wr_bena_b);
    end
    @(negedge clk);
    we = '0;
    ptr_m = 2;
  endtask

  task automatic test_round_robin();
    int c;
    do_reset();
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = 32'h100 + 32'(4 * i);
    we = '0;
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      logic [63:0] d;
      wait_en(c);
      total++;
      if (bus_rr.rden_b !== 1'b1 || bus_rr.addr_b !== 32'h100 + 32'(4 * (t % N))) begin
        bad++;
        $display("FAIL rr_grant t=%0d rden=%b addr=%h exp requester %0d", t, bus_rr.rden_b, bus_rr.addr_b, t % N);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      d = {$urandom, $urandom};
      bus_rr.valid_b = 1'b1;
      bus_rr.rd_data = d;
      @(negedge clk);
      bus_rr.valid_b = 1'b0;
      if (t == 5) req = '0;
      total++;
      if (ack !== 3'(1 << (t % N)) || rdata !== d) begin
        bad++;
        $display("FAIL rr_ack t=%0d ack=%b rdata=%h exp %b/%h", t, ack, rdata, 3'(1 << (t % N)), d);
      end
    end
    @(negedge clk);
    ptr_m = 0;
  endtask

  task automatic test_fixed_prio();
    int c;
    req_fx = 3'b111;
    for (int t = 0; t < 3; t++) begin
      c = 0;
      while (!bus_fx.rden_b && c < 100) begin
        @(negedge clk);
        c++;
      end
      total++;
      if (bus_fx.rden_b !== 1'b1 || bus_fx.addr_b !== 32'h100) begin
        bad++;
        $display("FAIL fx_grant t=%0d rden=%b addr=%h exp requester 0", t, bus_fx.rden_b, bus_fx.addr_b);
      end
      @(negedge clk);
      bus_fx.valid_b = 1'b1;
      bus_fx.rd_data = 64'hA5A5_0000_0000_0000 + 64'(t);
      @(negedge clk);
      bus_fx.valid_b = 1'b0;
      if (t == 2) req_fx = '0;
      total++;
      if (ack_fx !== 3'b001 || err_fx !== 3'b000 || rdata_fx !== 64'hA5A5_0000_0000_0000 + 64'(t)) begin
        bad++;
        $display("FAIL fx_ack t=%0d ack=%b err=%b rdata=%h exp 001/000", t, ack_fx, err_fx, rdata_fx);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_not_ready();
    int c;
    int hits;
    do_reset();
    bus_rr.ram_rdy_n = 1'b1;
    we = '0;
    req = 3'b111;
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_rr.rden_b || bus_rr.wren_b) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL not_ready_idle enable_cycles=%0d exp 0", hits);
    end
    bus_rr.ram_rdy_n = 1'b0;
    wait_en(c);
    total++;
    if (bus_rr.rden_b !== 1'b1 || bus_rr.addr_b !== 32'h100) begin
      bad++;
      $display("FAIL not_ready_release rden=%b addr=%h exp requester 0", bus_rr.rden_b, bus_rr.addr_b);
    end
    bus_rr.valid_b = 1'b1;
    @(negedge clk);
    bus_rr.valid_b = 1'b0;
    req = '0;
    @(negedge clk);
    ptr_m = 1;
  endtask

  task automatic test_timeout();
    int c;
    int n;
    do_reset();
    we = '0;
    req = 3'b011;
    wait_en(c);
    n = 1;
    while (bus_rr.rden_b && n < 100) begin
      @(negedge clk);
      if (bus_rr.rden_b) n++;
    end
    total++;
    if (n != TO) begin
      bad++;
      $display("FAIL to_len rden_cycles=%0d exp %0d", n, TO);
    end
    total++;
    if (err !== 3'b001 || ack !== 3'b000) begin
      bad++;
      $display("FAIL to_err err=%b ack=%b exp 001/000", err, ack);
    end
    req = 3'b010;
    @(negedge clk);
    total++;
    if (err !== 3'b000 || bus_rr.rden_b !== 1'b1 || bus_rr.addr_b !== 32'h104) begin
      bad++;
      $display("FAIL to_next err=%b rden=%b addr=%h exp 000/1/00000104", err, bus_rr.rden_b, bus_rr.addr_b);
    end
    bus_rr.valid_b = 1'b1;
    @(negedge clk);
    bus_rr.valid_b = 1'b0;
    req = '0;
    total++;
    if (ack !== 3'b010) begin
      bad++;
      $display("FAIL to_next_ack ack=%b exp 010", ack);
    end
    @(negedge clk);
    ptr_m = 2;
  endtask

  task automatic test_reset_mid_write();
    int c;
    do_reset();
    we = 3'b010;
    bena[8 +: 8] = 8'hFF;
    req = 3'b010;
    wait_en(c);
    @(negedge clk);
    bus_rr.fetch_b = 1'b1;
    @(negedge clk);
    bus_rr.fetch_b = 1'b0;
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    total++;
    if ({bus_rr.rden_b, bus_rr.wren_b, bus_rr.wr_bena_b, ack, err} !== '0) begin
      bad++;
      $display("FAIL rst_mid wren=%b bena=%h ack=%b err=%b exp all 0", bus_rr.wren_b, bus_rr.wr_bena_b, ack, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ack !== 3'b000 || err !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_noack ack=%b err=%b exp 000/000", ack, err);
    end
    ptr_m = 0;
    we = '0;
    req = 3'b111;
    wait_en(c);
    total++;
    if (bus_rr.rden_b !== 1'b1 || bus_rr.addr_b !== 32'h100) begin
      bad++;
      $display("FAIL rst_mid_regrant rden=%b addr=%h exp requester 0", bus_rr.rden_b, bus_rr.addr_b);
    end
    bus_rr.valid_b = 1'b1;
    @(negedge clk);
    bus_rr.valid_b = 1'b0;
    req = '0;
    @(negedge clk);
    ptr_m = 1;
  endtask

  task automatic test_random();
    int c;
    int g;
    int lat;
    logic [N-1:0]  r;
    logic [AW-1:0] ea;
    logic [63:0]   ed;
    logic [7:0]    eb;
    logic [63:0]   d;
    for (int it = 0; it < 24; it++) begin
      r = 3'($urandom_range(1, 7));
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = $urandom;
        wdata[i*64 +: 64] = {$urandom, $urandom};
        bena[i*8 +: 8] = 8'($urandom);
        we[i] = 1'($urandom);
      end
      g = rr_pick(r);
      ea = addr[g*AW +: AW];
      ed = wdata[g*64 +: 64];
      eb = bena[g*8 +: 8];
      req = r;
      wait_en(c);
      total++;
      if (bus_rr.addr_b !== ea || {bus_rr.wren_b, bus_rr.rden_b} !== {we[g], ~we[g]}) begin
        bad++;
        $display("FAIL rnd_grant it=%0d addr=%h wren/rden=%b%b exp %h we=%b (req %0d)",
                 it, bus_rr.addr_b, bus_rr.wren_b, bus_rr.rden_b, ea, we[g], g);
      end
      addr[g*AW +: AW] = ~ea;
      wdata[g*64 +: 64] = ~ed;
      bena[g*8 +: 8] = ~eb;
      lat = $urandom_range(1, 6);
      if (!we[g]) begin
        bus_rr.fetch_b = 1'b1;
        @(negedge clk);
        bus_rr.fetch_b = 1'b0;
        repeat (lat - 1) @(negedge clk);
        d = {$urandom, $urandom};
        bus_rr.valid_b = 1'b1;
        bus_rr.rd_data = d;
        @(negedge clk);
        bus_rr.valid_b = 1'b0;
        req = '0;
        total++;
        if (ack !== 3'(1 << g) || rdata !== d || bus_rr.addr_b !== ea) begin
          bad++;
          $display("FAIL rnd_rd it=%0d ack=%b rdata=%h addr=%h exp %b/%h/%h", it, ack, rdata, bus_rr.addr_b,
                   3'(1 << g), d, ea);
        end
      end else begin
        bus_rr.valid_b = 1'b1;
        repeat (lat) @(negedge clk);
        bus_rr.valid_b = 1'b0;
        bus_rr.fetch_b = 1'b1;
        @(negedge clk);
        bus_rr.fetch_b = 1'b0;
        @(negedge clk);
        total++;
        if (bus_rr.wr_data_b !== ed || bus_rr.wr_bena_b !== eb || bus_rr.wren_b !== 1'b0) begin
          bad++;
          $display("FAIL rnd_wr_p2 it=%0d data=%h bena=%h wren=%b exp %h/%h/0", it, bus_rr.wr_data_b,
                   bus_rr.wr_bena_b, bus_rr.wren_b, ed, eb);
        end
        @(negedge clk);
        req = '0;
        total++;
        if (ack !== 3'(1 << g) || bus_rr.wr_bena_b !== 8'h00) begin
          bad++;
          $display("FAIL rnd_wr_ack it=%0d ack=%b bena=%h exp %b/00", it, ack, bus_rr.wr_bena_b, 3'(1 << g));
        end
      end
      ptr_m = (g + 1) % N;
      @(negedge clk);
      total++;
      if (ack !== 3'b000 || err !== 3'b000) begin
        bad++;
        $display("FAIL rnd_pulse it=%0d ack=%b err=%b exp 000/000", it, ack, err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_fx = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    bena = '0;
    bus_rr.ram_rdy_n = 1'b0;
    bus_rr.rd_data = '0;
    bus_rr.valid_b = 1'b0;
    bus_rr.fetch_b = 1'b0;
    bus_fx.ram_rdy_n = 1'b0;
    bus_fx.rd_data = '0;
    bus_fx.valid_b = 1'b0;
    bus_fx.fetch_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_fixed_prio();
    test_not_ready();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
